// File: rtl/brq_pkg.sv
// brq_pkg: shared types and constants for the branch resolve queue.
//   brq_entry_t        : one tracked fetch slot {pc, predTaken, predTarget}
//   mispredict_cause_e : why a popped entry is being redirected
//   INSN_BYTES         : fall-through increment for the correct PC
//   classify()         : compares a recorded prediction with the EX outcome
package brq_pkg;

    localparam int INSN_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        predTaken;
        logic [31:0] predTarget;
    } brq_entry_t;

    typedef enum logic [1:0] {
        MP_NONE,
        MP_DIR,
        MP_TGT,
        MP_ALIAS
    } mispredict_cause_e;

    // Direction error wins over target error. A non-branch that the
    // predictor called taken is a BTB alias and also needs a redirect.
    function automatic mispredict_cause_e classify(
        input brq_entry_t  e,
        input logic        is_branch,
        input logic        taken,
        input logic [31:0] target
    );
        if (is_branch) begin
            if (e.predTaken != taken) return MP_DIR;
            if (taken && (e.predTarget != target)) return MP_TGT;
            return MP_NONE;
        end
        if (e.predTaken) return MP_ALIAS;
        return MP_NONE;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: generic circular buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write one entry (ignored when full)
//   pop           : retire the head entry (ignored when empty)
//   clear         : discard all entries; overrides push and pop
//   rdata         : head entry (meaningless while empty)
//   count         : number of valid entries
//   full, empty   : derived from the registered count
module brq_fifo #(
    parameter int  DEPTH = 4,
    parameter int  CNT_W = $clog2(DEPTH) + 1,
    parameter type T     = logic [7:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  T                 wdata,
    output T                 rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of fetched predictions, resolved
// against EX outcomes. Produces a registered fetch redirect on mispredict
// and a registered predictor-update stream.
//
// Optional feature macro: BRQ_STATS_EN adds statBranches/statMispredicts.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   fqValid/fqReady               enqueue handshake, with fqPc,
//                                 fqPredTaken, fqPredTarget
//   exValid                       pop/resolve head, with exIsBranch,
//                                 exActualTaken, exActualTarget, exPcIn
//   flushIn                       external flush, drops same-cycle pop/push
//   updBranch/updTaken/updPc/updTarget  registered predictor update
//   redirectValid/redirectPc      registered fetch redirect
//   occupancy                     valid entries
//   errSticky                     protocol error seen (cleared by rst only)
//   statBranches/statMispredicts  saturating counters (BRQ_STATS_EN only)
//
// Handshake: an entry is accepted on a clock edge where fqValid && fqReady;
// fqReady depends only on registered occupancy, never on fqValid or exValid,
// so a pop in the same cycle as a full queue does not open the slot early.
// exValid has no ready: it is a one-cycle request that pops the head.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fqValid,
    output logic             fqReady,
    input  logic [31:0]      fqPc,
    input  logic             fqPredTaken,
    input  logic [31:0]      fqPredTarget,
    input  logic             exValid,
    input  logic             exIsBranch,
    input  logic             exActualTaken,
    input  logic [31:0]      exActualTarget,
    input  logic [31:0]      exPcIn,
    input  logic             flushIn,
    output logic             updBranch,
    output logic             updTaken,
    output logic [31:0]      updPc,
    output logic [31:0]      updTarget,
    output logic             redirectValid,
    output logic [31:0]      redirectPc,
    output logic [CNT_W-1:0] occupancy,
    output logic             errSticky
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]      statBranches,
    output logic [31:0]      statMispredicts
`endif
);

    brq_entry_t        head;
    brq_entry_t        wentry;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              pop_ok;
    logic              push_ok;
    logic              mispredict;
    logic              clear;
    logic              err_set;
    logic [31:0]       correct_pc;
    mispredict_cause_e cause;

    assign wentry = '{pc: fqPc, predTaken: fqPredTaken, predTarget: fqPredTarget};

    assign fqReady   = !full;
    assign occupancy = count;

    // A flush suppresses resolution entirely: no update, no redirect.
    assign pop_ok = exValid && !empty && !flushIn;

    always_comb begin
        cause = classify(head, exIsBranch, exActualTaken, exActualTarget);
    end

    assign mispredict = pop_ok && (cause != MP_NONE);
    assign correct_pc = (exIsBranch && exActualTaken) ? exActualTarget
                                                      : head.pc + 32'(INSN_BYTES);

    // Everything younger than a mispredicted head is wrong-path, including
    // whatever fetch offers this cycle.
    assign clear   = flushIn || mispredict;
    assign push_ok = fqValid && fqReady && !clear;

    // Resolution still proceeds on a PC mismatch; only the flag records it.
    assign err_set = exValid && (empty || (exPcIn != head.pc));

    brq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .T     (brq_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop_ok),
        .clear (clear),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            updBranch     <= 1'b0;
            updTaken      <= 1'b0;
            updPc         <= '0;
            updTarget     <= '0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            errSticky     <= 1'b0;
        end else begin
            updBranch     <= pop_ok && exIsBranch;
            updTaken      <= pop_ok && exIsBranch && exActualTaken;
            updPc         <= (pop_ok && exIsBranch) ? head.pc : '0;
            updTarget     <= (pop_ok && exIsBranch) ? exActualTarget : '0;
            redirectValid <= mispredict;
            redirectPc    <= mispredict ? correct_pc : '0;
            if (err_set) errSticky <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else begin
            if (pop_ok && exIsBranch && (statBranches != 32'hFFFF_FFFF))
                statBranches <= statBranches + 32'd1;
            if (mispredict && (statMispredicts != 32'hFFFF_FFFF))
                statMispredicts <= statMispredicts + 32'd1;
        end
    end
`endif

endmodule
